// File: rtl/dram_bridge_pkg.sv
// Shared types and helpers for the 32-bit core port to 128-bit DRAM line bridge.
package dram_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        DONE
    } bridge_state_t;

    localparam int unsigned WORDS_PER_LINE   = 4;
    localparam int unsigned LINE_OFFSET_BITS = 4;

    // DRAM mask is active-high "do not write": only the addressed word lane is opened.
    function automatic logic [15:0] lane_mask(input logic [1:0] lane, input logic [3:0] wstrb);
        logic [15:0] m;
        m = '1;
        m[4*lane +: 4] = ~wstrb;
        return m;
    endfunction

    function automatic logic [31:0] word_of(input logic [127:0] line, input logic [1:0] idx);
        return line[32*idx +: 32];
    endfunction

endpackage

// File: rtl/dram_line_buffer.sv
// One-line read buffer: holds the last DRAM line fetched, with tag compare and write merge.
module dram_line_buffer
    import dram_bridge_pkg::*;
#(
    parameter int TAG_W = 24
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [TAG_W-1:0] lookup_tag,
    input  logic [1:0]       word_sel,
    output logic             hit,
    output logic [31:0]      rd_word,
    input  logic             fill_en,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic [127:0]     fill_line,
    input  logic             merge_en,
    input  logic [1:0]       merge_lane,
    input  logic [3:0]       merge_strb,
    input  logic [31:0]      merge_data
);

    logic [127:0]     line_q;
    logic [TAG_W-1:0] tag_q;
    logic             valid_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            line_q  <= '0;
        end else if (fill_en) begin
            valid_q <= 1'b1;
            tag_q   <= fill_tag;
            line_q  <= fill_line;
        end else if (merge_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (merge_strb[b]) begin
                    line_q[32*merge_lane + 8*b +: 8] <= merge_data[8*b +: 8];
                end
            end
        end
    end

    assign hit     = valid_q && (tag_q == lookup_tag);
    assign rd_word = word_of(line_q, word_sel);

endmodule

// File: rtl/dram_word_bridge.sv
// Bridges single-word reads and byte-strobed writes onto 128-bit DRAM line commands,
// one command outstanding, with a one-line read buffer in front of DRAM.
module dram_word_bridge
    import dram_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128,
    parameter int MASK_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  i_ren,
    input  logic [31:0]           i_raddr,
    output logic                  o_rvalid,
    output logic [31:0]           o_rdata,
    input  logic                  i_wen,
    input  logic [31:0]           i_waddr,
    input  logic [3:0]            i_wstrb,
    input  logic [31:0]           i_wdata,
    output logic                  o_wready,
    output logic                  o_dram_ren,
    output logic                  o_dram_wen,
    output logic [ADDR_WIDTH-2:0] o_dram_addr,
    output logic [DATA_WIDTH-1:0] o_dram_wdata,
    output logic [MASK_WIDTH-1:0] o_dram_wmask,
    output logic                  o_dram_user_busy,
    input  logic                  i_dram_init_calib_complete,
    input  logic                  i_dram_busy,
    input  logic [DATA_WIDTH-1:0] i_dram_rdata,
    input  logic                  i_dram_rdata_valid
);

    localparam int TAG_W = ADDR_WIDTH - LINE_OFFSET_BITS;

    bridge_state_t           state;
    logic [ADDR_WIDTH-1:2]   addr_q;
    logic [3:0]              wstrb_q;
    logic [31:0]             wdata_q;
    logic [TAG_W-1:0]        lookup_tag;
    logic                    buf_hit;
    logic [31:0]             buf_word;
    logic                    fill_en;
    logic                    merge_en;
    logic                    unused_addr_bits;

    assign o_dram_user_busy = 1'b0;
    assign unused_addr_bits = ^{i_raddr[31:ADDR_WIDTH], i_raddr[1:0],
                                i_waddr[31:ADDR_WIDTH], i_waddr[1:0]};

    // The single tag comparator serves the read lookup in IDLE and the write-merge check in WR_REQ.
    always_comb begin
        lookup_tag = i_raddr[ADDR_WIDTH-1:LINE_OFFSET_BITS];
        if (state == WR_REQ) begin
            lookup_tag = addr_q[ADDR_WIDTH-1:LINE_OFFSET_BITS];
        end
        fill_en  = (state == RD_WAIT) && i_dram_rdata_valid;
        merge_en = (state == WR_REQ) && !i_dram_busy && buf_hit;
    end

    dram_line_buffer #(.TAG_W(TAG_W)) u_line_buffer (
        .clock      (clock),
        .resetn     (resetn),
        .lookup_tag (lookup_tag),
        .word_sel   (i_raddr[3:2]),
        .hit        (buf_hit),
        .rd_word    (buf_word),
        .fill_en    (fill_en),
        .fill_tag   (addr_q[ADDR_WIDTH-1:LINE_OFFSET_BITS]),
        .fill_line  (i_dram_rdata),
        .merge_en   (merge_en),
        .merge_lane (addr_q[3:2]),
        .merge_strb (wstrb_q),
        .merge_data (wdata_q)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state        <= IDLE;
            addr_q       <= '0;
            wstrb_q      <= '0;
            wdata_q      <= '0;
            o_rvalid     <= 1'b0;
            o_rdata      <= '0;
            o_wready     <= 1'b0;
            o_dram_ren   <= 1'b0;
            o_dram_wen   <= 1'b0;
            o_dram_addr  <= '0;
            o_dram_wdata <= '0;
            o_dram_wmask <= '0;
        end else begin
            o_rvalid <= 1'b0;
            o_wready <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_dram_init_calib_complete) begin
                        if (i_wen) begin
                            addr_q       <= i_waddr[ADDR_WIDTH-1:2];
                            wstrb_q      <= i_wstrb;
                            wdata_q      <= i_wdata;
                            o_dram_wen   <= 1'b1;
                            o_dram_addr  <= {i_waddr[ADDR_WIDTH-1:LINE_OFFSET_BITS], 3'b000};
                            o_dram_wdata <= {WORDS_PER_LINE{i_wdata}};
                            o_dram_wmask <= lane_mask(i_waddr[3:2], i_wstrb);
                            state        <= WR_REQ;
                        end else if (i_ren) begin
                            addr_q <= i_raddr[ADDR_WIDTH-1:2];
                            if (buf_hit) begin
                                o_rdata  <= buf_word;
                                o_rvalid <= 1'b1;
                                state    <= DONE;
                            end else begin
                                o_dram_ren  <= 1'b1;
                                o_dram_addr <= {i_raddr[ADDR_WIDTH-1:LINE_OFFSET_BITS], 3'b000};
                                state       <= RD_REQ;
                            end
                        end
                    end
                end
                RD_REQ: begin
                    if (!i_dram_busy) begin
                        o_dram_ren <= 1'b0;
                        state      <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (i_dram_rdata_valid) begin
                        o_rdata  <= word_of(i_dram_rdata, addr_q[3:2]);
                        o_rvalid <= 1'b1;
                        state    <= DONE;
                    end
                end
                WR_REQ: begin
                    if (!i_dram_busy) begin
                        o_dram_wen <= 1'b0;
                        o_wready   <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_word_bridge.sv
// Self-checking bench for dram_word_bridge: directed scenarios plus randomized traffic vs. a memory model.
module tb_dram_word_bridge;

    logic         clock;
    logic         resetn;
    logic         i_ren;
    logic [31:0]  i_raddr;
    logic         o_rvalid;
    logic [31:0]  o_rdata;
    logic         i_wen;
    logic [31:0]  i_waddr;
    logic [3:0]   i_wstrb;
    logic [31:0]  i_wdata;
    logic         o_wready;
    logic         o_dram_ren;
    logic         o_dram_wen;
    logic [26:0]  o_dram_addr;
    logic [127:0] o_dram_wdata;
    logic [15:0]  o_dram_wmask;
    logic         o_dram_user_busy;
    logic         i_dram_init_calib_complete;
    logic         i_dram_busy;
    logic [127:0] i_dram_rdata;
    logic         i_dram_rdata_valid;

    int unsigned asserts = 0;
    int unsigned fails   = 0;

    // Model: byte-addressed memory (word granular, 2^28 alias) plus which line the bridge holds.
    logic [31:0] mem [logic [25:0]];
    bit          cache_valid;
    logic [23:0] cache_line;

    dram_word_bridge #(.ADDR_WIDTH(28), .DATA_WIDTH(128), .MASK_WIDTH(16)) dut (
        .clock                      (clock),
        .resetn                     (resetn),
        .i_ren                      (i_ren),
        .i_raddr                    (i_raddr),
        .o_rvalid                   (o_rvalid),
        .o_rdata                    (o_rdata),
        .i_wen                      (i_wen),
        .i_waddr                    (i_waddr),
        .i_wstrb                    (i_wstrb),
        .i_wdata                    (i_wdata),
        .o_wready                   (o_wready),
        .o_dram_ren                 (o_dram_ren),
        .o_dram_wen                 (o_dram_wen),
        .o_dram_addr                (o_dram_addr),
        .o_dram_wdata               (o_dram_wdata),
        .o_dram_wmask               (o_dram_wmask),
        .o_dram_user_busy           (o_dram_user_busy),
        .i_dram_init_calib_complete (i_dram_init_calib_complete),
        .i_dram_busy                (i_dram_busy),
        .i_dram_rdata               (i_dram_rdata),
        .i_dram_rdata_valid         (i_dram_rdata_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] mem_rd(input logic [25:0] w);
        if (mem.exists(w)) return mem[w];
        return {w[15:0], w[15:0] ^ 16'hFFFF};
    endfunction

    task automatic mem_wr(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data);
        logic [31:0] cur;
        cur = mem_rd(addr[27:2]);
        for (int b = 0; b < 4; b++) if (strb[b]) cur[8*b +: 8] = data[8*b +: 8];
        mem[addr[27:2]] = cur;
    endtask

    function automatic logic [127:0] line_of(input logic [26:0] da);
        logic [127:0] l;
        logic [1:0]   j2;
        for (int j = 0; j < 4; j++) begin
            j2 = j[1:0];
            l[32*j +: 32] = mem_rd({da[26:3], j2});
        end
        return l;
    endfunction

    function automatic logic [15:0] exp_mask(input logic [31:0] addr, input logic [3:0] strb);
        logic [15:0] m;
        int          lane;
        m = 16'hFFFF;
        lane = int'(addr[3:2]);
        for (int b = 0; b < 4; b++) if (strb[b]) m[lane*4 + b] = 1'b0;
        return m;
    endfunction

    task automatic do_reset();
        resetn = 1'b0; i_ren = 1'b0; i_wen = 1'b0; i_dram_busy = 1'b0; i_dram_rdata_valid = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        cache_valid = 1'b0;
        tick();
    endtask

    // Read driver acting as requester and DRAM responder; no checks here.
    task automatic bus_read(input logic [31:0] addr, input int unsigned rbusy, input int unsigned lat,
                            output logic [31:0] data, output int unsigned n, output bit used,
                            output logic [26:0] daddr, output bit stable, output int unsigned lag,
                            output bit ok, output bit extra);
        int unsigned bleft, cd, vn;
        bit waiting;
        data = '0; n = 0; used = 0; daddr = '0; stable = 1; lag = 0; ok = 0; extra = 0;
        bleft = rbusy; cd = 0; vn = 0; waiting = 0;
        i_raddr = addr; i_ren = 1'b1; i_dram_busy = (rbusy > 0);
        for (int i = 0; i < 200; i++) begin
            tick(); n++;
            i_dram_rdata_valid = 1'b0;
            if (o_rvalid) begin data = o_rdata; ok = 1; lag = n - vn; break; end
            if (o_dram_ren && !waiting) begin
                if (!used) begin used = 1; daddr = o_dram_addr; end
                else if (o_dram_addr !== daddr) stable = 0;
                if (bleft > 0) bleft--;
                if (bleft == 0) begin i_dram_busy = 1'b0; waiting = 1; cd = (lat == 0) ? 1 : lat; end
            end else if (waiting && cd > 0) begin
                cd--;
                if (cd == 0) begin i_dram_rdata = line_of(daddr); i_dram_rdata_valid = 1'b1; vn = n; end
            end
        end
        i_ren = 1'b0; i_dram_busy = 1'b0; i_dram_rdata_valid = 1'b0;
        if (ok) begin tick(); extra = o_rvalid || o_wready; end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data,
                             input int unsigned wbusy, output int unsigned n, output logic [15:0] mask,
                             output logic [127:0] wd, output logic [26:0] daddr, output bit stable,
                             output int unsigned wen_cycles, output bit saw_ren, output bit ok,
                             output bit extra);
        int unsigned bleft;
        n = 0; mask = '0; wd = '0; daddr = '0; stable = 1; wen_cycles = 0; saw_ren = 0; ok = 0; extra = 0;
        i_waddr = addr; i_wstrb = strb; i_wdata = data; i_wen = 1'b1;
        i_dram_busy = (wbusy > 0); bleft = wbusy;
        for (int i = 0; i < 200; i++) begin
            tick(); n++;
            if (o_dram_ren) saw_ren = 1;
            if (o_wready) begin ok = 1; break; end
            if (o_dram_wen) begin
                if (wen_cycles == 0) begin mask = o_dram_wmask; wd = o_dram_wdata; daddr = o_dram_addr; end
                else if ({o_dram_wmask, o_dram_wdata, o_dram_addr} !== {mask, wd, daddr}) stable = 0;
                wen_cycles++;
                if (bleft > 0) bleft--;
                if (bleft == 0) i_dram_busy = 1'b0;
            end
        end
        i_wen = 1'b0; i_dram_busy = 1'b0;
        if (ok) begin tick(); extra = o_wready || o_rvalid; end
    endtask

    task automatic test_reset();
        logic [197:0] outs;
        resetn = 1'b0; i_ren = 1'b1; i_wen = 1'b1; i_raddr = 32'h40; i_waddr = 32'h80;
        i_wstrb = 4'hF; i_wdata = 32'h1234_5678; i_dram_init_calib_complete = 1'b1;
        i_dram_busy = 1'b0; i_dram_rdata = '1; i_dram_rdata_valid = 1'b1;
        repeat (3) tick();
        outs = {o_rvalid, o_rdata, o_wready, o_dram_ren, o_dram_wen, o_dram_addr,
                o_dram_wdata, o_dram_wmask, o_dram_user_busy};
        asserts++;
        if (outs !== '0) begin fails++; $display("FAIL reset_outputs: got %h want 0", outs); end
        i_ren = 1'b0; i_wen = 1'b0; i_dram_rdata_valid = 1'b0; i_dram_init_calib_complete = 1'b0;
        resetn = 1'b1;
        cache_valid = 1'b0;
        tick();
    endtask

    task automatic test_calib_gate();
        int unsigned bad;
        bad = 0;
        i_raddr = 32'h100; i_ren = 1'b1;
        repeat (20) begin tick(); if (o_dram_ren || o_rvalid) bad++; end
        asserts++;
        if (bad != 0) begin fails++; $display("FAIL calib_gate: got %0d active cycles want 0", bad); end
        i_dram_init_calib_complete = 1'b1;
        tick();
        asserts++;
        if (o_dram_ren !== 1'b1) begin fails++; $display("FAIL calib_ren: got %b want 1", o_dram_ren); end
        asserts++;
        if (o_dram_addr !== 27'h80) begin fails++; $display("FAIL calib_addr: got %h want 80", o_dram_addr); end
        tick();
        i_dram_rdata = line_of(27'h80); i_dram_rdata_valid = 1'b1;
        tick();
        i_dram_rdata_valid = 1'b0;
        asserts++;
        if ({o_rvalid, o_rdata} !== {1'b1, mem_rd(26'h40)})
            begin fails++; $display("FAIL calib_rdata: got %b/%h want 1/%h", o_rvalid, o_rdata, mem_rd(26'h40)); end
        i_ren = 1'b0;
        tick();
        cache_valid = 1'b1; cache_line = 24'h10;
    endtask

    task automatic test_read_miss_hit();
        logic [31:0] d; int unsigned n, lag; bit used, stable, ok, extra; logic [26:0] da;
        do_reset();
        mem[26'h40] = 32'h1111_1111; mem[26'h41] = 32'h2222_2222;
        mem[26'h42] = 32'h3333_3333; mem[26'h43] = 32'h4444_4444;
        bus_read(32'h104, 0, 2, d, n, used, da, stable, lag, ok, extra);
        asserts++;
        if ({ok, used, da} !== {1'b1, 1'b1, 27'h80})
            begin fails++; $display("FAIL miss_issue: got ok=%b ren=%b addr=%h want 1/1/80", ok, used, da); end
        asserts++;
        if (d !== 32'h2222_2222) begin fails++; $display("FAIL miss_data: got %h want 22222222", d); end
        asserts++;
        if (lag != 1 || extra) begin fails++; $display("FAIL miss_latency: got lag=%0d extra=%b want 1/0", lag, extra); end
        cache_valid = 1'b1; cache_line = 24'h10;
        bus_read(32'h10C, 0, 2, d, n, used, da, stable, lag, ok, extra);
        asserts++;
        if ({ok, used, n} !== {1'b1, 1'b0, 32'd1})
            begin fails++; $display("FAIL hit_path: got ok=%b ren=%b cycles=%0d want 1/0/1", ok, used, n); end
        asserts++;
        if (d !== 32'h4444_4444) begin fails++; $display("FAIL hit_data: got %h want 44444444", d); end
    endtask

    task automatic test_write_merge();
        logic [31:0] d; int unsigned n, lag, wc; bit used, stable, ok, extra, sr;
        logic [26:0] da; logic [15:0] m; logic [127:0] wd;
        bus_write(32'h108, 4'b0011, 32'hAABB_CCDD, 0, n, m, wd, da, stable, wc, sr, ok, extra);
        asserts++;
        if (m !== 16'hFCFF) begin fails++; $display("FAIL wr_mask: got %h want FCFF", m); end
        asserts++;
        if (wd !== {4{32'hAABB_CCDD}}) begin fails++; $display("FAIL wr_data: got %h want 4xAABBCCDD", wd); end
        asserts++;
        if ({ok, da, n, extra} !== {1'b1, 27'h80, 32'd2, 1'b0})
            begin fails++; $display("FAIL wr_handshake: got ok=%b addr=%h cycles=%0d extra=%b want 1/80/2/0", ok, da, n, extra); end
        mem_wr(32'h108, 4'b0011, 32'hAABB_CCDD);
        bus_read(32'h108, 0, 1, d, n, used, da, stable, lag, ok, extra);
        asserts++;
        if ({ok, used, d} !== {1'b1, 1'b0, 32'h3333_CCDD})
            begin fails++; $display("FAIL merge_read: got ok=%b ren=%b data=%h want 1/0/3333CCDD", ok, used, d); end
        bus_write(32'h104, 4'b0000, 32'hDEAD_BEEF, 0, n, m, wd, da, stable, wc, sr, ok, extra);
        asserts++;
        if ({ok, m} !== {1'b1, 16'hFFFF}) begin fails++; $display("FAIL zero_strb: got ok=%b mask=%h want 1/FFFF", ok, m); end
        bus_read(32'h104, 0, 1, d, n, used, da, stable, lag, ok, extra);
        asserts++;
        if ({used, d} !== {1'b0, 32'h2222_2222})
            begin fails++; $display("FAIL zero_strb_buf: got ren=%b data=%h want 0/22222222", used, d); end
    endtask

    task automatic test_busy_backpressure();
        logic [31:0] d; int unsigned n, lag, wc; bit used, stable, ok, extra, sr;
        logic [26:0] da; logic [15:0] m; logic [127:0] wd;
        bus_write(32'h10C, 4'b1000, 32'h9900_0000, 5, n, m, wd, da, stable, wc, sr, ok, extra);
        asserts++;
        if ({stable, wc} !== {1'b1, 32'd5}) begin fails++; $display("FAIL busy_hold: got stable=%b cycles=%0d want 1/5", stable, wc); end
        asserts++;
        if ({ok, n, extra} !== {1'b1, 32'd6, 1'b0})
            begin fails++; $display("FAIL busy_wready: got ok=%b cycles=%0d extra=%b want 1/6/0", ok, n, extra); end
        mem_wr(32'h10C, 4'b1000, 32'h9900_0000);
        bus_read(32'h10C, 0, 1, d, n, used, da, stable, lag, ok, extra);
        asserts++;
        if ({used, d} !== {1'b0, 32'h9944_4444})
            begin fails++; $display("FAIL busy_merge: got ren=%b data=%h want 0/99444444", used, d); end
    endtask

    task automatic test_priority();
        logic [31:0] d; int unsigned n, lag, wc; bit used, stable, ok, extra, sr;
        logic [26:0] da; logic [15:0] m; logic [127:0] wd;
        i_raddr = 32'h200; i_ren = 1'b1;
        bus_write(32'h300, 4'hF, 32'h1234_5678, 0, n, m, wd, da, stable, wc, sr, ok, extra);
        asserts++;
        if ({ok, sr, da} !== {1'b1, 1'b0, 27'h180})
            begin fails++; $display("FAIL prio_write: got ok=%b ren=%b addr=%h want 1/0/180", ok, sr, da); end
        mem_wr(32'h300, 4'hF, 32'h1234_5678);
        bus_read(32'h200, 2, 3, d, n, used, da, stable, lag, ok, extra);
        asserts++;
        if ({ok, used, stable, da, d} !== {1'b1, 1'b1, 1'b1, 27'h100, mem_rd(26'h80)})
            begin fails++; $display("FAIL prio_read: got ok=%b ren=%b stable=%b addr=%h data=%h want 1/1/1/100/%h", ok, used, stable, da, d, mem_rd(26'h80)); end
        cache_valid = 1'b1; cache_line = 24'h20;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; int unsigned n, lag, cnt; bit used, stable, ok, extra; logic [26:0] da;
        do_reset();
        i_raddr = 32'h400; i_ren = 1'b1;
        tick();
        asserts++;
        if (o_dram_ren !== 1'b1) begin fails++; $display("FAIL rmid_ren: got %b want 1", o_dram_ren); end
        tick();
        resetn = 1'b0; i_ren = 1'b0;
        tick();
        resetn = 1'b1; cache_valid = 1'b0;
        i_dram_rdata = line_of(27'h200); i_dram_rdata_valid = 1'b1;
        tick();
        i_dram_rdata_valid = 1'b0;
        cnt = 0;
        repeat (5) begin if (o_rvalid) cnt++; tick(); end
        asserts++;
        if (cnt != 0) begin fails++; $display("FAIL rmid_stale: got %0d rvalid cycles want 0", cnt); end
        bus_read(32'h404, 0, 1, d, n, used, da, stable, lag, ok, extra);
        asserts++;
        if ({ok, used, da, d} !== {1'b1, 1'b1, 27'h200, mem_rd(26'h101)})
            begin fails++; $display("FAIL rmid_reread: got ok=%b ren=%b addr=%h data=%h want 1/1/200/%h", ok, used, da, d, mem_rd(26'h101)); end
        cache_valid = 1'b1; cache_line = 24'h40;
    endtask

    task automatic test_random();
        logic [31:0] r, addr, d, data; logic [23:0] ln; logic [1:0] wsel; logic [3:0] strb;
        int unsigned n, lag, wc, bsy, lat; bit used, stable, ok, extra, sr, exp_hit;
        logic [26:0] da; logic [15:0] m; logic [127:0] wd;
        for (int k = 0; k < 80; k++) begin
            r = $urandom();
            ln = 24'hABCD0 + 24'($urandom_range(0, 3));
            wsel = 2'($urandom_range(0, 3));
            addr = {r[31:28], ln, wsel, r[1:0]};
            if ($urandom_range(0, 2) == 0) begin
                strb = 4'($urandom_range(0, 15)); data = $urandom(); bsy = $urandom_range(0, 3);
                bus_write(addr, strb, data, bsy, n, m, wd, da, stable, wc, sr, ok, extra);
                asserts++;
                if ({ok, m, da} !== {1'b1, exp_mask(addr, strb), {ln, 3'b000}})
                    begin fails++; $display("FAIL rnd_wr_cmd[%0d]: got ok=%b mask=%h addr=%h want 1/%h/%h", k, ok, m, da, exp_mask(addr, strb), {ln, 3'b000}); end
                asserts++;
                if ({wd, stable, sr, extra} !== {{4{data}}, 1'b1, 1'b0, 1'b0})
                    begin fails++; $display("FAIL rnd_wr_data[%0d]: got %h stable=%b ren=%b extra=%b want %h/1/0/0", k, wd, stable, sr, extra, {4{data}}); end
                asserts++;
                if (n != ((bsy > 0) ? bsy : 1) + 1)
                    begin fails++; $display("FAIL rnd_wr_lat[%0d]: got %0d cycles want %0d", k, n, ((bsy > 0) ? bsy : 1) + 1); end
                if (ok) mem_wr(addr, strb, data);
            end else begin
                bsy = $urandom_range(0, 2); lat = $urandom_range(1, 4);
                exp_hit = cache_valid && (cache_line == addr[27:4]);
                bus_read(addr, bsy, lat, d, n, used, da, stable, lag, ok, extra);
                asserts++;
                if ({ok, d, extra} !== {1'b1, mem_rd(addr[27:2]), 1'b0})
                    begin fails++; $display("FAIL rnd_rd_data[%0d]: got ok=%b data=%h extra=%b want 1/%h/0", k, ok, d, extra, mem_rd(addr[27:2])); end
                asserts++;
                if (used !== !exp_hit) begin fails++; $display("FAIL rnd_rd_hit[%0d]: got dram_ren=%b want %b", k, used, !exp_hit); end
                if (!exp_hit) begin
                    asserts++;
                    if ({da, stable, lag} !== {ln, 3'b000, 1'b1, 32'd1})
                        begin fails++; $display("FAIL rnd_rd_miss[%0d]: got addr=%h stable=%b lag=%0d want %h/1/1", k, da, stable, lag, {ln, 3'b000}); end
                    cache_valid = 1'b1; cache_line = addr[27:4];
                end else begin
                    asserts++;
                    if (n != 1) begin fails++; $display("FAIL rnd_rd_hitlat[%0d]: got %0d cycles want 1", k, n); end
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        cache_valid = 1'b0; cache_line = '0;
        test_reset();
        test_calib_gate();
        test_read_miss_hit();
        test_write_merge();
        test_busy_backpressure();
        test_priority();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
